// File: rtl/tlcd_scheduler.sv
// rtl/tlcd_scheduler.sv - two-requester LCD line scheduler with init sequence and idle refresh
module tlcd_scheduler #(
    parameter int unsigned REFRESH_TICKS = 5000
) (
    input  logic         CLK,
    input  logic         RESETN,
    input  logic         REQ0,
    input  logic         REQ1,
    input  logic         LINE0,
    input  logic         LINE1,
    input  logic [127:0] TEXT0,
    input  logic [127:0] TEXT1,
    output logic         GNT0,
    output logic         GNT1,
    output logic         WR_VALID,
    output logic         WR_RS,
    output logic [7:0]   WR_DATA,
    input  logic         WR_READY,
    output logic         INIT_DONE,
    output logic         BUSY
);

    localparam int TW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'((REFRESH_TICKS == 0) ? 0 : REFRESH_TICKS - 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ADDR, ST_DATA} state_t;

    state_t         state;
    logic [1:0]     init_step;
    logic [3:0]     idx;
    logic [TW-1:0]  timer;
    logic           refresh_pending;
    logic           refresh_pass;
    logic           last_gnt;
    logic           line_sel;
    logic [127:0]   shadow_up;
    logic [127:0]   shadow_lo;
    logic [127:0]   cur_text;
    logic           pick1;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Character k sits at bits [(15-k)*8 +: 8]; for a 4-bit k, 15-k is ~k.
    function automatic logic [7:0] char_at(input logic [127:0] text, input logic [3:0] k);
        return text[{~k, 3'b000} +: 8];
    endfunction

    assign cur_text = line_sel ? shadow_lo : shadow_up;
    assign pick1    = REQ1 && (!REQ0 || !last_gnt);
    assign BUSY     = (state != ST_IDLE);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state           <= ST_INIT;
            init_step       <= 2'd0;
            idx             <= 4'd0;
            timer           <= '0;
            refresh_pending <= 1'b0;
            refresh_pass    <= 1'b0;
            last_gnt        <= 1'b1;
            line_sel        <= 1'b0;
            shadow_up       <= {16{8'h20}};
            shadow_lo       <= {16{8'h20}};
            GNT0            <= 1'b0;
            GNT1            <= 1'b0;
            WR_VALID        <= 1'b0;
            WR_RS           <= 1'b0;
            WR_DATA         <= 8'h00;
            INIT_DONE       <= 1'b0;
        end else begin
            GNT0 <= 1'b0;
            GNT1 <= 1'b0;
            if (state != ST_IDLE) begin
                timer <= '0;
            end
            case (state)
                ST_INIT: begin
                    if (!WR_VALID) begin
                        WR_VALID <= 1'b1;
                        WR_RS    <= 1'b0;
                        WR_DATA  <= init_cmd(init_step);
                    end else if (WR_READY) begin
                        if (init_step == 2'd3) begin
                            WR_VALID  <= 1'b0;
                            INIT_DONE <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            init_step <= init_step + 2'd1;
                            WR_DATA   <= init_cmd(init_step + 2'd1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (REQ0 || REQ1) begin
                        if (pick1) begin
                            GNT1     <= 1'b1;
                            last_gnt <= 1'b1;
                            line_sel <= LINE1;
                            if (LINE1) shadow_lo <= TEXT1;
                            else       shadow_up <= TEXT1;
                        end else begin
                            GNT0     <= 1'b1;
                            last_gnt <= 1'b0;
                            line_sel <= LINE0;
                            if (LINE0) shadow_lo <= TEXT0;
                            else       shadow_up <= TEXT0;
                        end
                        refresh_pass <= 1'b0;
                        timer        <= '0;
                        state        <= ST_ADDR;
                    end else if (refresh_pending) begin
                        refresh_pending <= 1'b0;
                        refresh_pass    <= 1'b1;
                        line_sel        <= 1'b0;
                        timer           <= '0;
                        state           <= ST_ADDR;
                    end else if (REFRESH_TICKS != 0) begin
                        if (timer == TICK_LAST) begin
                            timer           <= '0;
                            refresh_pending <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (!WR_VALID) begin
                        WR_VALID <= 1'b1;
                        WR_RS    <= 1'b0;
                        WR_DATA  <= line_sel ? 8'hC0 : 8'h80;
                    end else if (WR_READY) begin
                        idx     <= 4'd0;
                        WR_RS   <= 1'b1;
                        WR_DATA <= char_at(cur_text, 4'd0);
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (WR_VALID && WR_READY) begin
                        if (idx == 4'd15) begin
                            // A refresh pass chains straight from the upper line into the lower one.
                            if (refresh_pass && !line_sel) begin
                                line_sel <= 1'b1;
                                WR_RS    <= 1'b0;
                                WR_DATA  <= 8'hC0;
                                state    <= ST_ADDR;
                            end else begin
                                WR_VALID     <= 1'b0;
                                refresh_pass <= 1'b0;
                                state        <= ST_IDLE;
                            end
                        end else begin
                            idx     <= idx + 4'd1;
                            WR_DATA <= char_at(cur_text, idx + 4'd1);
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_tlcd_scheduler.sv
// tb/tb_tlcd_scheduler.sv - scoreboard bench for tlcd_scheduler with a line-level reference model
module tb_tlcd_scheduler;
    localparam int TICKS = 8;

    logic         CLK = 1'b0;
    logic         RESETN = 1'b1;
    logic         REQ0 = 1'b0, REQ1 = 1'b0, LINE0 = 1'b0, LINE1 = 1'b0;
    logic [127:0] TEXT0 = '0, TEXT1 = '0;
    logic         WR_READY = 1'b1;
    logic         GNT0, GNT1, WR_VALID, WR_RS, INIT_DONE, BUSY;
    logic [7:0]   WR_DATA;

    int checks = 0;
    int failures = 0;

    logic [8:0]   exp_q[$];
    logic [127:0] sh[0:1];
    int           init_left = 4;
    int           last_g = 1;
    int           timer_m = 0;
    bit           pend_m = 1'b0;
    logic [1:0]   exp_gnt = 2'b00;
    int           grant_log[$];
    bit           prev_stall = 1'b0;
    logic [8:0]   prev_byte = '0;
    bit           ready_force = 1'b1;
    bit           ready_val = 1'b1;

    tlcd_scheduler #(.REFRESH_TICKS(TICKS)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .REQ0(REQ0), .REQ1(REQ1), .LINE0(LINE0), .LINE1(LINE1),
        .TEXT0(TEXT0), .TEXT1(TEXT1),
        .GNT0(GNT0), .GNT1(GNT1),
        .WR_VALID(WR_VALID), .WR_RS(WR_RS), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
        .INIT_DONE(INIT_DONE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        WR_READY = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
        init_left  = 4;
        sh[0]      = {16{8'h20}};
        sh[1]      = {16{8'h20}};
        last_g     = 1;
        timer_m    = 0;
        pend_m     = 1'b0;
        exp_gnt    = 2'b00;
        prev_stall = 1'b0;
    endfunction

    function automatic void push_line(input logic ln);
        exp_q.push_back({1'b0, ln ? 8'hC0 : 8'h80});
        for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, sh[ln][(15 - k) * 8 +: 8]});
    endfunction

    // Monitor: checks everything the DUT shows each cycle and advances the reference model.
    always @(negedge CLK) begin
        logic [8:0] e;
        bit         busy_m;
        int         w;
        if (!RESETN) begin
            model_reset();
        end else begin
            busy_m = (init_left != 0) || (exp_q.size() != 0);
            if (exp_gnt != 2'b00 || {GNT1, GNT0} != 2'b00)
                check("gnt", 32'({GNT1, GNT0}), 32'(exp_gnt));
            if (GNT0) grant_log.push_back(0);
            if (GNT1) grant_log.push_back(1);
            exp_gnt = 2'b00;
            check("busy", 32'(BUSY), 32'(busy_m));
            check("init_done", 32'(INIT_DONE), 32'(init_left == 0));
            if (prev_stall)
                check("stall_stable", 32'({WR_VALID, WR_RS, WR_DATA}), 32'({1'b1, prev_byte}));
            prev_stall = WR_VALID && !WR_READY;
            prev_byte  = {WR_RS, WR_DATA};
            if (WR_VALID && WR_READY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'({WR_RS, WR_DATA}), 32'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 32'({WR_RS, WR_DATA}), 32'(e));
                    if (init_left > 0) init_left--;
                end
            end
            if (!busy_m) begin
                if (REQ0 || REQ1) begin
                    w = (REQ0 && REQ1) ? ((last_g == 0) ? 1 : 0) : (REQ1 ? 1 : 0);
                    last_g  = w;
                    exp_gnt = (w == 1) ? 2'b10 : 2'b01;
                    if (w == 1) begin sh[LINE1] = TEXT1; push_line(LINE1); end
                    else        begin sh[LINE0] = TEXT0; push_line(LINE0); end
                    timer_m = 0;
                end else if (pend_m) begin
                    pend_m = 1'b0;
                    push_line(1'b0);
                    push_line(1'b1);
                    timer_m = 0;
                end else if (timer_m == TICKS - 1) begin
                    timer_m = 0;
                    pend_m  = 1'b1;
                end else begin
                    timer_m++;
                end
            end else begin
                timer_m = 0;
            end
        end
    end

    task automatic wait_quiet(input int max);
        for (int i = 0; i < max; i++) begin
            @(posedge CLK); #2;
            if (init_left == 0 && exp_q.size() == 0 && !BUSY) return;
        end
        check("quiet_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_req(input int n, input logic ln, input logic [127:0] txt, input int max);
        @(posedge CLK); #1;
        if (n == 0) begin REQ0 = 1'b1; LINE0 = ln; TEXT0 = txt; end
        else        begin REQ1 = 1'b1; LINE1 = ln; TEXT1 = txt; end
        for (int i = 0; i < max; i++) begin
            @(posedge CLK); #1;
            if ((n == 0 && GNT0) || (n == 1 && GNT1)) begin
                REQ0 = (n == 0) ? 1'b0 : REQ0;
                REQ1 = (n == 1) ? 1'b0 : REQ1;
                return;
            end
        end
        check("grant_timeout", 32'd1, 32'd0);
        REQ0 = 1'b0;
        REQ1 = 1'b0;
    endtask

    task automatic wait_char(input logic [7:0] ch, input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(posedge CLK); #2;
            if (WR_VALID && WR_RS && WR_DATA == ch) begin found = 1'b1; return; end
        end
    endtask

    initial begin
        #500000;
        checks++;
        failures++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int         base;
        bit         found;
        logic [127:0] digits;
        digits = "0123456789ABCDEF";

        #1 RESETN = 1'b0;
        #1;
        check("rst_wr_valid", 32'(WR_VALID), 32'd0);
        check("rst_wr_rs", 32'(WR_RS), 32'd0);
        check("rst_wr_data", 32'(WR_DATA), 32'd0);
        check("rst_gnt", 32'({GNT1, GNT0}), 32'd0);
        check("rst_init_done", 32'(INIT_DONE), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd1);
        repeat (2) @(posedge CLK);
        #2 RESETN = 1'b1;

        // Init with WR_READY tied high, and requests ignored during INIT.
        REQ1 = 1'b0;
        wait_quiet(50);
        check("init_done_after_init", 32'(INIT_DONE), 32'd1);

        // Simultaneous requests: round-robin from reset gives 0, 1, 0.
        base = grant_log.size();
        @(posedge CLK); #1;
        REQ0 = 1'b1; LINE0 = 1'b1; TEXT0 = "first requester ";
        REQ1 = 1'b1; LINE1 = 1'b1; TEXT1 = "second requester";
        for (int i = 0; i < 300 && grant_log.size() < base + 3; i++) begin
            @(posedge CLK); #1;
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        check("rr_count", 32'(grant_log.size() >= base + 3), 32'd1);
        if (grant_log.size() >= base + 3) begin
            check("rr_first", 32'(grant_log[base]), 32'd0);
            check("rr_second", 32'(grant_log[base + 1]), 32'd1);
            check("rr_third", 32'(grant_log[base + 2]), 32'd0);
        end
        wait_quiet(200);

        do_req(0, 1'b1, "HELLO WORLD     ", 100);
        wait_quiet(200);

        // Lower line only, then let the idle refresh run from the shadows.
        do_req(1, 1'b1, "ABCDEFGHIJKLMNOP", 100);
        wait_quiet(200);
        wait_char("A", 100, found);
        check("refresh_seen", 32'(found), 32'd1);
        wait_quiet(200);

        // Long stall at character index 5.
        do_req(0, 1'b0, digits, 100);
        wait_char("4", 100, found);
        check("stall_reach", 32'(found), 32'd1);
        ready_val = 1'b0;
        @(posedge CLK); #2;
        check("stall_char5", 32'({WR_VALID, WR_RS, WR_DATA}), 32'({2'b11, 8'h35}));
        repeat (20) @(posedge CLK);
        ready_val = 1'b1;
        wait_quiet(200);

        // Randomized traffic with random backpressure and abandoned requests.
        ready_force = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK); #1;
            if (REQ0) begin
                if (GNT0 || $urandom_range(0, 39) == 0) REQ0 = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                REQ0 = 1'b1; LINE0 = 1'($urandom_range(0, 1));
                TEXT0 = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (REQ1) begin
                if (GNT1 || $urandom_range(0, 39) == 0) REQ1 = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                REQ1 = 1'b1; LINE1 = 1'($urandom_range(0, 1));
                TEXT1 = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        ready_force = 1'b1; ready_val = 1'b1;
        wait_quiet(400);

        // Reset in the middle of a line write at index 9.
        do_req(0, 1'b0, digits, 100);
        wait_char("9", 100, found);
        check("reset_reach", 32'(found), 32'd1);
        RESETN = 1'b0;
        #1;
        check("async_wr_valid", 32'(WR_VALID), 32'd0);
        check("async_wr_data", 32'({WR_RS, WR_DATA}), 32'd0);
        check("async_init_done", 32'(INIT_DONE), 32'd0);
        check("async_busy", 32'(BUSY), 32'd1);
        repeat (2) @(posedge CLK);
        #2 RESETN = 1'b1;
        wait_quiet(100);
        // Shadows are back to blanks: wait for a refresh to rewrite them.
        wait_char(8'h20, 100, found);
        check("post_reset_refresh", 32'(found), 32'd1);
        wait_quiet(200);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tlcd_scheduler.md
TLCD_SCHEDULER -- requirements
Module: tlcd_scheduler

Interface
REQ-001 Parameter REFRESH_TICKS, default 5000, sets the idle-refresh period in CLK cycles (1 s at 5 kHz); a value of 0 disables refresh.
REQ-002 CLK  input  1  5 kHz system clock; all state changes on the rising edge.
REQ-003 RESETN  input  1  reset, asynchronous, active-low.
REQ-004 REQ0, REQ1  input  1 each  requester n wants one line written; held high until GNTn.
REQ-005 LINE0, LINE1  input  1 each  target line for requester n: 0 = upper, 1 = lower.
REQ-006 TEXT0, TEXT1  input  128 each  16 characters for requester n; character k is bits [(15-k)*8 +: 8].
REQ-007 GNT0, GNT1  output  1 each  one-cycle grant pulse; LINEn/TEXTn are captured on that edge.
REQ-008 WR_VALID  output  1  byte offered to the downstream LCD byte writer.
REQ-009 WR_RS  output  1  0 = command, 1 = character data.
REQ-010 WR_DATA  output  8  byte value.
REQ-011 WR_READY  input  1  downstream accepts the byte on any edge where WR_VALID=1 and WR_READY=1.
REQ-012 INIT_DONE  output  1  high once the init sequence has completed; stays high until reset.
REQ-013 BUSY  output  1  high in every state except IDLE.

Function
REQ-014 States: INIT, IDLE, ADDR, DATA.
- A byte is accepted when WR_VALID=1 and WR_READY=1 on an edge.
- The next byte may be presented in the following cycle.
REQ-015 While WR_VALID=1, WR_RS and WR_DATA are held stable until the byte is accepted.
REQ-016 INIT issues four commands with RS=0, in order: 0x38, 0x0C, 0x06, 0x01.
- The edge that accepts 0x01 moves to IDLE and sets INIT_DONE.
REQ-017 REQ0 and REQ1 are ignored in INIT; no GNT is issued there.
REQ-018 IDLE arbitration uses round-robin between REQ0 and REQ1.
- A lone request wins immediately.
- On a tie, the requester not granted last wins.
- After reset, requester 0 wins the first tie.
REQ-019 On a grant:
- GNTn pulses for exactly one cycle.
- TEXTn is copied into the shadow of the selected line, and the line select is latched.
- The state moves to ADDR.
- Grant to accepted byte is at least one cycle.
REQ-020 ADDR issues RS=0 with 0x80 for the upper line or 0xC0 for the lower line, then goes to DATA with index 0.
REQ-021 DATA issues RS=1 with shadow character[index]; the index increments on each accepted byte.
- Acceptance of index 15 ends the line write.
- The index is 4 bits and never wraps mid-line.
REQ-022 At end of line, a refresh pass with the upper line just written continues to ADDR for the lower line; otherwise the state returns to IDLE.
REQ-023 The refresh timer counts only in IDLE when REFRESH_TICKS != 0.
- On reaching REFRESH_TICKS-1 it sets refresh_pending and restarts from 0.
- The timer is cleared whenever the state leaves IDLE.
REQ-024 In IDLE with no REQ and refresh_pending=1:
- refresh_pending is cleared.
- The block rewrites the upper line then the lower line from the shadows.
- No GNT is issued.
REQ-025 Requests take priority over a pending refresh; refresh_pending persists until served.
REQ-026 A requester dropping REQ before its GNT receives no grant and causes no write.
REQ-027 Requests arriving while BUSY wait; they are evaluated in the first IDLE cycle.
REQ-028 WR_READY held low stalls the block indefinitely with all outputs held; there is no timeout.
REQ-029 GNT0 and GNT1 are never high in the same cycle.

Reset
REQ-030 RESETN low asynchronously forces:
- state INIT with the init step at 0.
- WR_VALID=0, WR_RS=0, WR_DATA=0x00.
- GNT0=GNT1=0, INIT_DONE=0, BUSY=1.
- refresh timer 0, refresh_pending=0, round-robin pointer favouring requester 0.
- both shadows set to 16 x 0x20.
REQ-031 Reset asserted mid-transfer abandons the byte immediately.
- After release, the block restarts at INIT with 0x38.

Verification
REQ-032 WR_READY tied high, no requests -> bytes 0x38, 0x0C, 0x06, 0x01 (RS=0) on consecutive accepts; INIT_DONE rises; BUSY falls.
REQ-033 REQ0 with LINE0=1 and TEXT0="HELLO WORLD     " -> one GNT0 pulse; then 0xC0 (RS=0) followed by 'H','E','L',...,0x20 (RS=1), 17 bytes total.
REQ-034 REQ0 and REQ1 held together for three grants -> grant order GNT0, GNT1, GNT0; each followed by a full 17-byte line write.
REQ-035 REFRESH_TICKS=8, idle after one lower-line write of "ABC..." -> 8 idle cycles, then 0x80 with 16 x 0x20, then 0xC0 with "ABC..."; no GNT.
REQ-036 WR_READY held low for 20 cycles at DATA index 5 -> WR_VALID, WR_RS and WR_DATA stable for all 20 cycles; index 5 sent once when WR_READY rises.
REQ-037 RESETN pulsed low at DATA index 9 -> WR_VALID drops asynchronously; after release the first byte is 0x38 and INIT_DONE=0 until init completes.
